// File: rtl/sccb_write_master.sv
// SCCB (OV7670) write-only master: sends {CAM_ADDR, addr, data} as a 3-phase write.
// All pins are registered and derived from the next-state values, so they stay cycle-aligned with ready.
module sccb_write_master #(
   parameter int         CLK_FREQ  = 27000000,
   parameter int         SCCB_FREQ = 100000,
   parameter logic [7:0] CAM_ADDR  = 8'h42
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] data,
   output logic       ready,
   output logic       sioc,
   output logic       siod_out,
   output logic       siod_oe
);

   localparam int QTR_RAW = CLK_FREQ / (4 * SCCB_FREQ);
   localparam int QTR     = (QTR_RAW < 1) ? 1 : QTR_RAW;
   localparam int TW      = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(QTR - 1);

   typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

   typedef struct packed {
      logic ready;
      logic sioc;
      logic siod;
      logic oe;
   } pins_t;

   state_t        state, state_n;
   logic [TW-1:0] tick, tick_n;
   logic [1:0]    qtr, qtr_n;
   logic [4:0]    bit_cnt, bit_n;
   logic [1:0]    byte_cnt, byte_n;
   logic [23:0]   sreg, sreg_n;
   pins_t         pins_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tick     <= '0;
         qtr      <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         sreg     <= '0;
         ready    <= 1'b1;
         sioc     <= 1'b1;
         siod_out <= 1'b1;
         siod_oe  <= 1'b1;
      end else begin
         state    <= state_n;
         tick     <= tick_n;
         qtr      <= qtr_n;
         bit_cnt  <= bit_n;
         byte_cnt <= byte_n;
         sreg     <= sreg_n;
         ready    <= pins_n.ready;
         sioc     <= pins_n.sioc;
         siod_out <= pins_n.siod;
         siod_oe  <= pins_n.oe;
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick;
      qtr_n   = qtr;
      bit_n   = bit_cnt;
      byte_n  = byte_cnt;
      sreg_n  = sreg;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = START;
               tick_n  = '0;
               qtr_n   = '0;
               bit_n   = '0;
               byte_n  = '0;
               sreg_n  = {CAM_ADDR, addr, data};
            end
         end
         START, BITS, STOP: begin
            if (tick != TICK_LAST) begin
               tick_n = tick + 1'b1;
            end else begin
               tick_n = '0;
               qtr_n  = qtr + 2'd1;
               if (state == START && qtr == 2'd1) begin
                  state_n = BITS;
                  qtr_n   = '0;
               end else if (state == BITS && qtr == 2'd3) begin
                  // slot 8 is the don't-care bit: no shift, advance to next byte
                  if (bit_cnt == 5'd8) begin
                     bit_n = '0;
                     if (byte_cnt == 2'd2) begin
                        state_n = STOP;
                        byte_n  = '0;
                     end else begin
                        byte_n = byte_cnt + 2'd1;
                     end
                  end else begin
                     bit_n  = bit_cnt + 5'd1;
                     sreg_n = {sreg[22:0], 1'b0};
                  end
               end else if (state == STOP && qtr == 2'd3) begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tick_n  = '0;
            qtr_n   = '0;
            bit_n   = '0;
            byte_n  = '0;
         end
      endcase
   end

   always_comb begin
      pins_n = '1;
      case (state_n)
         START: begin
            pins_n.ready = 1'b0;
            pins_n.sioc  = (qtr_n == 2'd0);
            pins_n.siod  = 1'b0;
         end
         BITS: begin
            pins_n.ready = 1'b0;
            pins_n.sioc  = qtr_n[1];
            if (bit_n == 5'd8) begin
               pins_n.siod = 1'b0;
               pins_n.oe   = 1'b0;
            end else begin
               pins_n.siod = sreg_n[23];
            end
         end
         STOP: begin
            pins_n.ready = 1'b0;
            pins_n.sioc  = (qtr_n != 2'd0);
            pins_n.siod  = qtr_n[1];
         end
         default: pins_n = '1;
      endcase
   end

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed/randomized bench for sccb_write_master: decodes SIOD at SIOC rising edges and
// compares frames, busy length and bus-protocol counts against a frame-level model.
module tb_sccb_write_master;
   localparam int         QTR  = 10;
   localparam int         BUSY = 114 * QTR;
   localparam logic [7:0] CAM  = 8'h42;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] addr = '0;
   logic [7:0] data = '0;
   logic       ready, sioc, siod_out, siod_oe;

   int checks = 0;
   int failures = 0;

   sccb_write_master #(.CLK_FREQ(400), .SCCB_FREQ(10), .CAM_ADDR(CAM)) dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data),
      .ready(ready), .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe)
   );

   always #5 clk = ~clk;

   // bus monitor: SIOD captured on SIOC rise, SIOD edges while SIOC held high, released-line time
   logic rise_siod[$];
   logic rise_oe[$];
   logic prev_sioc = 1'b1;
   logic prev_siod = 1'b1;
   int   hi_fall = 0;
   int   hi_rise = 0;
   int   oe_low = 0;

   always @(negedge clk) begin
      if (!prev_sioc && sioc) begin
         rise_siod.push_back(siod_out);
         rise_oe.push_back(siod_oe);
      end
      if (prev_sioc && sioc && siod_out !== prev_siod) begin
         if (siod_out) hi_rise++;
         else hi_fall++;
      end
      if (!siod_oe) oe_low++;
      prev_sioc = sioc;
      prev_siod = siod_out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] d, input int poke_at, input int rst_at);
      int         n, base, f0, r0, o0, oe_ones;
      logic [7:0] exp_b[3];
      logic [7:0] got;
      exp_b[0] = CAM; exp_b[1] = a; exp_b[2] = d;
      n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(n < 3000), 1);
      base = rise_siod.size(); f0 = hi_fall; r0 = hi_rise; o0 = oe_low;
      addr = a; data = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ready_low_next", 32'(ready), 0);
      n = 0;
      while (ready === 1'b0 && n < 2000) begin
         n++;
         if (n == poke_at) begin
            start = 1'b1; addr = 8'h11; data = ~d;
         end
         if (n == poke_at + 1) begin
            start = 1'b0; addr = a; data = d;
         end
         if (n == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_ready", 32'(ready), 1);
            check("abort_sioc", 32'(sioc), 1);
            check("abort_oe", 32'(siod_oe), 1);
            check("abort_siod", 32'(siod_out), 1);
            return;
         end
         @(negedge clk);
      end
      check("busy_len", n, BUSY);
      // 27 bit slots plus the STOP rise
      check("rise_count", rise_siod.size() - base, 28);
      if (rise_siod.size() >= base + 28) begin
         for (int k = 0; k < 3; k++) begin
            got = '0;
            oe_ones = 0;
            for (int i = 0; i < 8; i++) begin
               got = {got[6:0], rise_siod[base + 9*k + i]};
               if (rise_oe[base + 9*k + i] === 1'b1) oe_ones++;
            end
            check($sformatf("byte%0d", k), got, exp_b[k]);
            check($sformatf("byte%0d_oe", k), oe_ones, 8);
            check($sformatf("ack%0d_oe", k), 32'(rise_oe[base + 9*k + 8]), 0);
         end
         check("stop_rise_siod", 32'(rise_siod[base + 27]), 0);
      end
      check("start_fall", hi_fall - f0, 1);
      check("stop_rise", hi_rise - r0, 1);
      check("oe_low_cycles", oe_low - o0, 3 * 4 * QTR);
   endtask

   initial begin
      int         r0;
      logic [7:0] ra, rd;
      rst = 1'b1; start = 1'b1; addr = 8'h55; data = 8'hAA;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 1);
      check("rst_sioc", 32'(sioc), 1);
      check("rst_siod", 32'(siod_out), 1);
      check("rst_oe", 32'(siod_oe), 1);
      r0 = rise_siod.size();
      rst = 1'b0; start = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_ready", 32'(ready), 1);
      check("idle_sioc", 32'(sioc), 1);
      check("idle_rises", rise_siod.size() - r0, 0);

      run_frame(8'h12, 8'h80, 300, 0);
      run_frame(8'h3A, 8'h04, 0, 0);
      for (int i = 0; i < 3; i++) begin
         ra = 8'($urandom); rd = 8'($urandom);
         run_frame(ra, rd, 0, 0);
      end
      ra = 8'($urandom); rd = 8'($urandom);
      run_frame(ra, rd, 0, 500);
      ra = 8'($urandom); rd = 8'($urandom);
      run_frame(ra, rd, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
